// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_unit
//  Purpose  : Iterative multiply/divide unit for the execution stage. It
//             performs MULT/MULTU/DIV/DIVU (one bit per cycle) and owns the
//             HI/LO registers, which can also be written directly (MTHI/MTLO).
//  Ports    : clk, rst            - clock (rising edge), async active-high reset
//             start, mul_control  - request + one-hot op (MULT,MULTU,DIV,DIVU)
//             src_a, src_b        - rs / rt operands, latched on acceptance
//             mthi_we, mtlo_we,
//             mt_data             - direct HI/LO writes
//             flush               - cancel an in-flight operation
//             busy, done          - operation in flight / result-written pulse
//             hi, lo              - architectural HI/LO registers
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       mul_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             mthi_we,
  input  logic             mtlo_we,
  input  logic [WIDTH-1:0] mt_data,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int              CW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0]   LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           op_q, op_d;
  // Shared accumulator: multiply {partial product, multiplier};
  // divide {partial remainder, dividend/quotient}.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0]     araw_q, araw_d;   // raw src_a, needed for divide-by-zero
  logic                 sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 done_q, done_d;

  // Operand decode at acceptance
  logic                 onehot, op_signed, op_is_mul;
  logic [WIDTH-1:0]     mag_a, mag_b;

  assign onehot    = (mul_control != 4'd0) && ((mul_control & (mul_control - 4'd1)) == 4'd0);
  assign op_signed = mul_control[0] | mul_control[2];
  assign op_is_mul = mul_control[0] | mul_control[1];
  assign mag_a     = (op_signed && src_a[WIDTH-1]) ? -src_a : src_a;
  assign mag_b     = (op_signed && src_b[WIDTH-1]) ? -src_b : src_b;

  // Shift-add multiply step: add multiplicand on multiplier LSB, shift right
  // with the carry kept in the top bit.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring divide step: shift in the next dividend bit, trial-subtract.
  logic [WIDTH:0]       rem_sh, diff;
  logic [2*WIDTH-1:0]   div_next;
  assign rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
  assign diff   = rem_sh - {1'b0, opnd_q};
  assign div_next = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                : {diff[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b1};

  // Sign fix-up and final HI/LO values
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     res_hi, res_lo;
  always_comb begin
    prod   = (op_q[0] && (sa_q ^ sb_q)) ? -acc_q : acc_q;
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (op_q[2] || op_q[3]) begin
      if (opnd_q == '0) begin
        // Divide by zero: fixed pattern, dividend passed through unsigned-fixed
        res_lo = '1;
        res_hi = araw_q;
      end else begin
        res_lo = (op_q[2] && (sa_q ^ sb_q)) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        res_hi = (op_q[2] && sa_q) ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    araw_d  = araw_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    if (mthi_we) hi_d = mt_data;
    if (mtlo_we) lo_d = mt_data;

    case (state_q)
      S_IDLE: begin
        if (start && onehot && !flush) begin
          state_d = S_CALC;
          cnt_d   = '0;
          op_d    = mul_control;
          sa_d    = op_signed & src_a[WIDTH-1];
          sb_d    = op_signed & src_b[WIDTH-1];
          araw_d  = src_a;
          if (op_is_mul) begin
            acc_d  = {{WIDTH{1'b0}}, mag_b};
            opnd_d = mag_a;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, mag_a};
            opnd_d = mag_b;
          end
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = (op_q[0] | op_q[1]) ? mul_next : div_next;
          if (cnt_q == LAST) begin
            state_d = S_FIX;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flush) begin
          // Operation result takes priority over a same-edge MTHI/MTLO
          hi_d   = res_hi;
          lo_d   = res_lo;
          done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      araw_q  <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      araw_q  <= araw_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_unit
//  Purpose  : Directed self-checking bench for muldiv_unit.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  localparam logic [3:0] C_MULT  = 4'b0001;
  localparam logic [3:0] C_MULTU = 4'b0010;
  localparam logic [3:0] C_DIV   = 4'b0100;
  localparam logic [3:0] C_DIVU  = 4'b1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  mul_control = 4'd0;
  logic [31:0] src_a = '0, src_b = '0;
  logic        mthi_we = 1'b0, mtlo_we = 1'b0;
  logic [31:0] mt_data = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int nvec = 0;
  int nerr = 0;
  int lat;
  bit early;
  bit seen;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32), .ITER(32)) dut (
    .clk(clk), .rst(rst), .start(start), .mul_control(mul_control),
    .src_a(src_a), .src_b(src_b), .mthi_we(mthi_we), .mtlo_we(mtlo_we),
    .mt_data(mt_data), .flush(flush), .busy(busy), .done(done),
    .hi(hi), .lo(lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] mc, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; mul_control = mc; src_a = a; src_b = b;
    tick();
    start = 1'b0; mul_control = 4'd0; src_a = 32'hDEADBEEF; src_b = 32'hCAFEF00D;
  endtask

  // Count edges until done; flags busy dropping before done. Bounded.
  task automatic wait_done(output int l, output bit e);
    l = -1;
    e = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done) begin l = i; break; end
      if (!busy) e = 1'b1;
    end
  endtask

  initial begin
    // Reset
    tick(); tick();
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    rst = 1'b0;
    tick();

    // MULTU max*max
    issue(C_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("multu_busy_e0", {63'd0, busy}, 64'd1);
    wait_done(lat, early);
    check("multu_latency", 64'(lat), 64'd33);
    check("multu_early_idle", {63'd0, early}, 64'd0);
    check("multu_busy_after", {63'd0, busy}, 64'd0);
    check("multu_hilo", {hi, lo}, 64'hFFFFFFFE_00000001);
    tick();
    check("multu_done_one_cycle", {63'd0, done}, 64'd0);

    // MULT -3*7 with a second start held through busy
    start = 1'b1; mul_control = C_MULT; src_a = 32'hFFFFFFFD; src_b = 32'd7;
    tick();
    mul_control = C_MULTU; src_a = 32'd2; src_b = 32'd3;
    wait_done(lat, early);
    check("mult_latency", 64'(lat), 64'd33);
    check("mult_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
    tick();  // E34: held start now accepted
    start = 1'b0; mul_control = 4'd0;
    check("start_e34_busy", {63'd0, busy}, 64'd1);
    wait_done(lat, early);
    check("start_e34_latency", 64'(lat), 64'd33);
    check("start_e34_hilo", {hi, lo}, 64'h00000000_00000006);

    // Invalid requests ignored
    issue(4'b0011, 32'd5, 32'd5);
    check("nononehot_ignored", {63'd0, busy}, 64'd0);
    issue(4'b0000, 32'd5, 32'd5);
    check("zero_ctrl_ignored", {63'd0, busy}, 64'd0);
    flush = 1'b1;
    issue(C_MULTU, 32'd5, 32'd5);
    flush = 1'b0;
    check("flush_start_ignored", {63'd0, busy}, 64'd0);

    // Divides
    issue(C_DIV, 32'hFFFFFFF9, 32'd2);
    wait_done(lat, early);
    check("div_neg7_2", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    issue(C_DIVU, 32'd7, 32'd0);
    wait_done(lat, early);
    check("divu_by_zero", {hi, lo}, 64'h00000007_FFFFFFFF);
    issue(C_DIV, 32'hFFFFFFF9, 32'd0);
    wait_done(lat, early);
    check("div_by_zero_nosignfix", {hi, lo}, 64'hFFFFFFF9_FFFFFFFF);
    issue(C_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done(lat, early);
    check("div_overflow", {hi, lo}, 64'h00000000_80000000);
    issue(C_DIVU, 32'd100, 32'd7);
    wait_done(lat, early);
    check("divu_100_7_latency", 64'(lat), 64'd33);
    check("divu_100_7", {hi, lo}, 64'h00000002_0000000E);

    // MTHI preload then flushed MULTU
    mthi_we = 1'b1; mt_data = 32'h12345678;
    tick();
    mthi_we = 1'b0;
    check("mthi_write", {hi, lo}, 64'h12345678_0000000E);
    issue(C_MULTU, 32'd2, 32'd3);
    repeat (9) tick();          // E1..E9
    flush = 1'b1;
    tick();                     // E10
    flush = 1'b0;
    check("flush_busy", {63'd0, busy}, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    check("flush_no_done", {63'd0, seen}, 64'd0);
    check("flush_hilo_kept", {hi, lo}, 64'h12345678_0000000E);

    // Rerun with MTLO mid-flight and MTHI colliding with the FIX edge
    issue(C_MULTU, 32'd2, 32'd3);
    repeat (4) tick();          // E1..E4
    mtlo_we = 1'b1; mt_data = 32'h000000AA;
    tick();                     // E5
    mtlo_we = 1'b0;
    check("mtlo_midflight", {32'd0, lo}, 64'h000000AA);
    repeat (27) tick();         // E6..E32
    check("mtlo_held_e32", {hi, lo}, 64'h12345678_000000AA);
    check("busy_e32", {63'd0, busy}, 64'd1);
    mthi_we = 1'b1; mt_data = 32'hDEADDEAD;
    tick();                     // E33
    mthi_we = 1'b0;
    check("fix_done", {63'd0, done}, 64'd1);
    check("fix_wins_over_mt", {hi, lo}, 64'h00000000_00000006);

    // Async reset mid-DIV
    issue(C_DIV, 32'd100, 32'd7);
    repeat (15) tick();         // E1..E15
    #2 rst = 1'b1;
    #1;
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_done", {63'd0, done}, 64'd0);
    check("arst_hilo", {hi, lo}, 64'd0);
    tick();
    rst = 1'b0;
    tick();
    issue(C_MULTU, 32'd4, 32'd5);
    wait_done(lat, early);
    check("post_reset_latency", 64'(lat), 64'd33);
    check("post_reset_multu", {hi, lo}, 64'h00000000_00000014);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
